// File: rtl/led7seg_pkg.sv
// Shared definitions for the 74HC595 LED-7-segment serial link:
// word layout, segment bit order, digit patterns and the receive-side decode.
package led7seg_pkg;

    localparam int WORD_W     = 16;
    localparam int NUM_DIGITS = 8;
    localparam int SEG_W      = 8;
    localparam int SEL_W      = 8;

    // Segment byte bit order, active-high; transmitter builds bytes with the same struct.
    typedef struct packed {
        logic dp;
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } seg_byte_t;

    // One serial word as shifted on the wire, MSB first.
    typedef struct packed {
        seg_byte_t          seg;
        logic [SEL_W-1:0]   sel;
    } link_word_t;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;
    localparam logic [7:0] SEG_4 = 8'h66;
    localparam logic [7:0] SEG_5 = 8'h6D;
    localparam logic [7:0] SEG_6 = 8'h7D;
    localparam logic [7:0] SEG_7 = 8'h07;
    localparam logic [7:0] SEG_8 = 8'h7F;
    localparam logic [7:0] SEG_9 = 8'h6F;

    localparam logic [3:0] BCD_BLANK = 4'hE;
    localparam logic [3:0] BCD_BAD   = 4'hF;

    // Segment byte back to a digit value; the decimal point never affects the result.
    function automatic logic [3:0] seg_decode(input logic [7:0] seg);
        logic [7:0] s;
        s = seg & 8'h7F;
        case (s)
            SEG_0:   seg_decode = 4'd0;
            SEG_1:   seg_decode = 4'd1;
            SEG_2:   seg_decode = 4'd2;
            SEG_3:   seg_decode = 4'd3;
            SEG_4:   seg_decode = 4'd4;
            SEG_5:   seg_decode = 4'd5;
            SEG_6:   seg_decode = 4'd6;
            SEG_7:   seg_decode = 4'd7;
            SEG_8:   seg_decode = 4'd8;
            SEG_9:   seg_decode = 4'd9;
            8'h00:   seg_decode = BCD_BLANK;
            default: seg_decode = BCD_BAD;
        endcase
    endfunction

endpackage

// File: rtl/line_sync_edge.sv
// Brings one asynchronous link line into the clk domain and flags its rising edge.
module line_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift the pin through the synchronizer; the history flop holds the previous synced value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // Synchronizer and history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];
    assign rise = sync & ~hist_q;

endmodule

// File: rtl/led7seg_74hc595_receiver.sv
// Receiving end of the 3-wire 74HC595 display link: shifts in {seg,sel} words,
// latches them on rclk, and mirrors the display into a segment/BCD frame buffer.
module led7seg_74hc595_receiver
    import led7seg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       rclk,
    input  logic                       dio,
    input  logic                       clr,
    output logic [WORD_W-1:0]          word,
    output logic                       word_vld,
    output logic [NUM_DIGITS*8-1:0]    seg_frame,
    output logic [NUM_DIGITS*4-1:0]    bcd_frame,
    output logic [NUM_DIGITS-1:0]      digit_mask,
    output logic                       err_len,
    output logic                       err_sel
);

    localparam int CNT_W = 5;

    logic sclk_rise, rclk_rise, dio_sync;

    line_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .sync(), .rise(sclk_rise)
    );
    line_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
        .clk(clk), .rst(rst), .d(rclk), .sync(), .rise(rclk_rise)
    );
    // dio only needs its level, sampled in the same cycle the sclk edge is seen.
    line_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dio (
        .clk(clk), .rst(rst), .d(dio), .sync(dio_sync), .rise()
    );

    logic [WORD_W-1:0]                 shreg_q, shreg_d;
    logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]                 word_q, word_d;
    logic                              word_vld_q, word_vld_d;
    logic [NUM_DIGITS-1:0][7:0]        seg_q, seg_d;
    logic [NUM_DIGITS-1:0][3:0]        bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]             mask_q, mask_d;
    logic                              err_len_q, err_len_d;
    logic                              err_sel_q, err_sel_d;

    link_word_t                        lw;
    logic                              sel_onehot;

    // Shift path and bit count: a same-cycle rclk sees the post-shift state.
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (sclk_rise) begin
            shreg_d = {shreg_q[WORD_W-2:0], dio_sync};
            if (bit_cnt_q != {CNT_W{1'b1}})
                bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (rclk_rise)
            bit_cnt_d = '0;
    end

    assign lw         = link_word_t'(shreg_d);
    assign sel_onehot = (lw.sel != '0) && ((lw.sel & (lw.sel - 1'b1)) == '0);

    // Latch, frame update and sticky errors; an error event overrides clr in the same cycle.
    always_comb begin
        word_d     = word_q;
        word_vld_d = 1'b0;
        seg_d      = seg_q;
        bcd_d      = bcd_q;
        mask_d     = mask_q;
        err_len_d  = err_len_q;
        err_sel_d  = err_sel_q;
        if (clr) begin
            mask_d    = '0;
            err_len_d = 1'b0;
            err_sel_d = 1'b0;
        end
        if (rclk_rise) begin
            word_d     = shreg_d;
            word_vld_d = 1'b1;
            // bit_cnt_d is cleared by the latch, so recompute the pre-clear count here.
            if ((sclk_rise ? ((bit_cnt_q == {CNT_W{1'b1}}) ? bit_cnt_q : bit_cnt_q + 1'b1)
                           : bit_cnt_q) != CNT_W'(WORD_W))
                err_len_d = 1'b1;
            if (sel_onehot) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (lw.sel[k]) begin
                        seg_d[k]  = lw.seg;
                        bcd_d[k]  = seg_decode(lw.seg);
                        mask_d[k] = 1'b1;
                    end
                end
            end else begin
                err_sel_d = 1'b1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            seg_q      <= '0;
            bcd_q      <= '0;
            mask_q     <= '0;
            err_len_q  <= 1'b0;
            err_sel_q  <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            seg_q      <= seg_d;
            bcd_q      <= bcd_d;
            mask_q     <= mask_d;
            err_len_q  <= err_len_d;
            err_sel_q  <= err_sel_d;
        end
    end

    assign word       = word_q;
    assign word_vld   = word_vld_q;
    assign seg_frame  = seg_q;
    assign bcd_frame  = bcd_q;
    assign digit_mask = mask_q;
    assign err_len    = err_len_q;
    assign err_sel    = err_sel_q;

endmodule

// File: tb/tb_led7seg_74hc595_receiver.sv
// Bench for the display-link receiver: table of words with expected frame state,
// plus hand-written reset, overlong, same-cycle and clr-vs-error sequences.
module tb_led7seg_74hc595_receiver;

    logic        clk = 1'b0, rst = 1'b0;
    logic        sclk = 1'b0, rclk = 1'b0, dio = 1'b0, clr = 1'b0;
    logic [15:0] word;
    logic        word_vld;
    logic [63:0] seg_frame;
    logic [31:0] bcd_frame;
    logic [7:0]  digit_mask;
    logic        err_len, err_sel;

    always #4 clk = ~clk;

    led7seg_74hc595_receiver dut (
        .clk(clk), .rst(rst), .sclk(sclk), .rclk(rclk), .dio(dio), .clr(clr),
        .word(word), .word_vld(word_vld), .seg_frame(seg_frame),
        .bcd_frame(bcd_frame), .digit_mask(digit_mask),
        .err_len(err_len), .err_sel(err_sel)
    );

    int          n_cmp = 0, n_bad = 0;
    logic [15:0] exp_q[$];
    logic [15:0] sr_m;
    logic [7:0]  seg_m[8];
    logic        vld_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: each word_vld pops the word expected at the matching rclk.
    always @(negedge clk) begin
        if (rst) begin
            if (word_vld) begin
                if (vld_prev) begin
                    n_cmp++; n_bad++;
                    $display("FAIL vld_width: word_vld high two cycles in a row");
                end
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL vld_spurious: got word %0h expected no pulse", word);
                end else begin
                    chk("sb_word", 64'(word), 64'(exp_q.pop_front()));
                end
            end
            vld_prev = word_vld;
        end else begin
            vld_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame model: only a one-hot sel updates the mirrored segment byte.
    task automatic model_latch(input logic [15:0] w);
        int ones;
        ones = 0;
        for (int k = 0; k < 8; k++) if (w[k]) ones++;
        if (ones == 1)
            for (int k = 0; k < 8; k++) if (w[k]) seg_m[k] = w[15:8];
        exp_q.push_back(w);
    endtask

    task automatic shift_bit(input logic b);
        dio = b;
        tick(4);
        sclk = 1'b1;
        sr_m = {sr_m[14:0], b};
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic latch();
        rclk = 1'b1;
        model_latch(sr_m);
        tick(4);
        rclk = 1'b0;
        tick(6);
    endtask

    task automatic send(input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) shift_bit(data[i]);
        latch();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(2);
    endtask

    task automatic check_state(input string tag, input logic [31:0] bcd, input logic [7:0] mask,
                               input logic el, input logic es);
        logic [63:0] sf;
        for (int k = 0; k < 8; k++) sf[8*k +: 8] = seg_m[k];
        chk({tag, ".bcd"},  64'(bcd_frame),  64'(bcd));
        chk({tag, ".mask"}, 64'(digit_mask), 64'(mask));
        chk({tag, ".elen"}, 64'(err_len),    64'(el));
        chk({tag, ".esel"}, 64'(err_sel),    64'(es));
        chk({tag, ".seg"},  seg_frame,       sf);
    endtask

    task automatic model_reset();
        sr_m = '0;
        for (int k = 0; k < 8; k++) seg_m[k] = 8'h00;
    endtask

    typedef struct {
        logic [31:0] data;
        int          nbits;   // 0 = clr pulse only
        logic [31:0] bcd;
        logic [7:0]  mask;
        logic        el;
        logic        es;
    } vec_t;

    vec_t vt[16];

    initial begin
        vt[0]  = '{32'h3F01, 16, 32'h00000000, 8'h01, 1'b0, 1'b0};
        vt[1]  = '{32'h0601, 16, 32'h00000001, 8'h01, 1'b0, 1'b0};
        vt[2]  = '{32'h5B02, 16, 32'h00000021, 8'h03, 1'b0, 1'b0};
        vt[3]  = '{32'h4F04, 16, 32'h00000321, 8'h07, 1'b0, 1'b0};
        vt[4]  = '{32'h6608, 16, 32'h00004321, 8'h0F, 1'b0, 1'b0};
        vt[5]  = '{32'h6D10, 16, 32'h00054321, 8'h1F, 1'b0, 1'b0};
        vt[6]  = '{32'h7D20, 16, 32'h00654321, 8'h3F, 1'b0, 1'b0};
        vt[7]  = '{32'h0740, 16, 32'h07654321, 8'h7F, 1'b0, 1'b0};
        vt[8]  = '{32'h7F80, 16, 32'h87654321, 8'hFF, 1'b0, 1'b0};
        vt[9]  = '{32'h0601, 15, 32'h87654321, 8'hFF, 1'b1, 1'b0};
        vt[10] = '{32'h3F01, 16, 32'h87654320, 8'hFF, 1'b1, 1'b0};
        vt[11] = '{32'h0000,  0, 32'h87654320, 8'h00, 1'b0, 1'b0};
        vt[12] = '{32'h4F03, 16, 32'h87654320, 8'h00, 1'b0, 1'b1};
        vt[13] = '{32'h5500, 16, 32'h87654320, 8'h00, 1'b0, 1'b1};
        vt[14] = '{32'h0004, 16, 32'h87654E20, 8'h04, 1'b0, 1'b1};
        vt[15] = '{32'h7704, 16, 32'h87654F20, 8'h04, 1'b0, 1'b1};

        model_reset();
        tick(3);
        chk("rst.word", 64'(word), 64'h0);
        chk("rst.vld",  64'(word_vld), 64'h0);
        check_state("rst", 32'h0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        tick(2);

        for (int i = 0; i < 16; i++) begin
            if (vt[i].nbits == 0) pulse_clr();
            else send(vt[i].data, vt[i].nbits);
            check_state($sformatf("vec%0d", i), vt[i].bcd, vt[i].mask, vt[i].el, vt[i].es);
        end

        // Reset in the middle of a word, then a clean word must be accepted.
        for (int i = 0; i < 9; i++) shift_bit(1'b1);
        rst = 1'b0;
        model_reset();
        tick(3);
        chk("midrst.word", 64'(word), 64'h0);
        check_state("midrst", 32'h0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        tick(2);
        send(32'h6D80, 16);
        check_state("after_rst", 32'h50000000, 8'h80, 1'b0, 1'b0);

        // 20 bits before rclk: last 16 bits land, length error raised.
        send(32'hA4F04, 20);
        check_state("long", 32'h50000300, 8'h84, 1'b1, 1'b0);
        pulse_clr();
        check_state("clr2", 32'h50000300, 8'h00, 1'b0, 1'b0);

        // 16th sclk and rclk rise together: shift lands first, count is 16.
        begin
            logic [15:0] w;
            w = 16'h6602;
            for (int i = 15; i >= 1; i--) shift_bit(w[i]);
            dio = w[0];
            tick(4);
            sclk = 1'b1;
            rclk = 1'b1;
            sr_m = {sr_m[14:0], w[0]};
            model_latch(sr_m);
            tick(4);
            sclk = 1'b0;
            rclk = 1'b0;
            tick(6);
        end
        check_state("simul", 32'h50000340, 8'h02, 1'b0, 1'b0);

        // Short word whose rclk edge coincides with clr: the error flag must survive.
        for (int i = 14; i >= 0; i--) shift_bit(1'(16'h0601 >> i));
        rclk = 1'b1;
        model_latch(sr_m);
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        rclk = 1'b0;
        tick(6);
        chk("clr_vs_err.elen", 64'(err_len), 64'h1);
        chk("clr_vs_err.bcd",  64'(bcd_frame), 64'h50000341);

        tick(4);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
